// File: rtl/logic_unit_scheduler.sv
// logic_unit_scheduler: round-robin sharing of one registered NOT/OR/AND/XOR unit among N requesters
module logic_unit_scheduler #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] op,
  input  logic [W*N-1:0] a,
  input  logic [W*N-1:0] b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   res,
  output logic           busy
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_d;
  logic [PW-1:0] ptr, off, win, ptr_nxt;
  logic [PW:0] sum;
  logic [N-1:0] rot;
  logic [1:0] cop;
  logic [W-1:0] ca, cb, f;
  logic start;
  assign rot = N'({req, req} >> ptr);
  assign busy = (state == EXEC);
  // winner is the first requester at or after ptr, wrapping; ptr then moves just past it
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? PW'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    win = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
    ptr_nxt = (win == PW'(N - 1)) ? '0 : win + PW'(1);
  end
  // IDLE launches on any request; EXEC always returns to IDLE after one cycle
  always_comb begin
    start = (state == IDLE) && |req;
    state_d = start ? EXEC : IDLE;
  end
  // shared gate function on the captured operands
  always_comb begin
    f = (cop == 2'b00) ? ~ca : (cop == 2'b01) ? (ca | cb) : (cop == 2'b10) ? (ca & cb) : (ca ^ cb);
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // grant/capture on launch, result and completion on the EXEC edge; gnt doubles as the captured grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt <= '0;
      done <= '0;
      res <= '0;
      ptr <= '0;
      cop <= '0;
      ca <= '0;
      cb <= '0;
    end else begin
      gnt <= start ? (N'(1) << win) : '0;
      done <= busy ? gnt : '0;
      if (start) begin
        ptr <= ptr_nxt;
        cop <= op[2*win +: 2];
        ca <= a[W*win +: W];
        cb <= b[W*win +: W];
      end
      if (busy) res <= f;
    end
  end
endmodule

// File: tb/tb_logic_unit_scheduler.sv
// tb_logic_unit_scheduler: directed vector table plus hand sequences for the shared logic unit scheduler
module tb_logic_unit_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, gnt, done;
  logic [7:0] op, res;
  logic [31:0] a, b;
  logic busy;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic rst_n;
    logic [3:0] req;
    logic [7:0] op;
    logic [31:0] a, b;
    logic [3:0] eg, ed;
    logic [7:0] er;
    logic eb;
  } vec_t;
  vec_t v[27];
  always #5 clk = ~clk;
  logic_unit_scheduler #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .done(done), .res(res), .busy(busy)
  );
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask
  task automatic apply(input vec_t t, input int idx);
    rst_n = t.rst_n;
    req = t.req;
    op = t.op;
    a = t.a;
    b = t.b;
    @(posedge clk);
    #1;
    chk("gnt", idx, 32'(gnt), 32'(t.eg));
    chk("done", idx, 32'(done), 32'(t.ed));
    chk("res", idx, 32'(res), 32'(t.er));
    chk("busy", idx, 32'(busy), 32'(t.eb));
  endtask
  initial begin
    v[0]  = '{1'b0, 4'hF, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0};
    v[1]  = '{1'b0, 4'hF, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0};
    v[2]  = '{1'b1, 4'hF, 8'h00, 32'h0, 32'h0, 4'h1, 4'h0, 8'h00, 1'b1};
    v[3]  = '{1'b1, 4'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h1, 8'hFF, 1'b0};
    v[4]  = '{1'b1, 4'h4, 8'h10, 32'h000F0000, 32'h00A00000, 4'h4, 4'h0, 8'hFF, 1'b1};
    v[5]  = '{1'b1, 4'h0, 8'h10, 32'h000F0000, 32'h00A00000, 4'h0, 4'h4, 8'hAF, 1'b0};
    v[6]  = '{1'b1, 4'h0, 8'h10, 32'h000F0000, 32'h00A00000, 4'h0, 4'h0, 8'hAF, 1'b0};
    v[7]  = '{1'b1, 4'h1, 8'h00, 32'h3C, 32'h0F, 4'h1, 4'h0, 8'hAF, 1'b1};
    v[8]  = '{1'b1, 4'h0, 8'h00, 32'h3C, 32'h0F, 4'h0, 4'h1, 8'hC3, 1'b0};
    v[9]  = '{1'b1, 4'h1, 8'h01, 32'h3C, 32'h0F, 4'h1, 4'h0, 8'hC3, 1'b1};
    v[10] = '{1'b1, 4'h0, 8'h01, 32'h3C, 32'h0F, 4'h0, 4'h1, 8'h3F, 1'b0};
    v[11] = '{1'b1, 4'h1, 8'h02, 32'h3C, 32'h0F, 4'h1, 4'h0, 8'h3F, 1'b1};
    v[12] = '{1'b1, 4'h0, 8'h02, 32'h3C, 32'h0F, 4'h0, 4'h1, 8'h0C, 1'b0};
    v[13] = '{1'b1, 4'h1, 8'h03, 32'h3C, 32'h0F, 4'h1, 4'h0, 8'h0C, 1'b1};
    v[14] = '{1'b1, 4'h0, 8'h03, 32'h3C, 32'h0F, 4'h0, 4'h1, 8'h33, 1'b0};
    v[15] = '{1'b0, 4'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0};
    v[16] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h1, 4'h0, 8'h00, 1'b1};
    v[17] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h0, 4'h1, 8'h1E, 1'b0};
    v[18] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h2, 4'h0, 8'h1E, 1'b1};
    v[19] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h0, 4'h2, 8'h2D, 1'b0};
    v[20] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h4, 4'h0, 8'h2D, 1'b1};
    v[21] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h0, 4'h4, 8'h3C, 1'b0};
    v[22] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h8, 4'h0, 8'h3C, 1'b1};
    v[23] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h0, 4'h8, 8'h4B, 1'b0};
    v[24] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h1, 4'h0, 8'h4B, 1'b1};
    v[25] = '{1'b1, 4'hF, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h0, 4'h1, 8'h1E, 1'b0};
    v[26] = '{1'b1, 4'h0, 8'hFF, 32'h44332211, 32'h0F0F0F0F, 4'h0, 4'h0, 8'h1E, 1'b0};
    for (int i = 0; i < 27; i++) apply(v[i], i);
    // operand stability: a changes in the gnt cycle, result uses the captured 8'h55
    apply('{1'b1, 4'h2, 8'h00, 32'h00005500, 32'h0, 4'h2, 4'h0, 8'h1E, 1'b1}, 100);
    apply('{1'b1, 4'h0, 8'h00, 32'h0000FF00, 32'h0, 4'h0, 4'h2, 8'hAA, 1'b0}, 101);
    // reset during EXEC: no done, res cleared, ptr back to 0
    apply('{1'b1, 4'h1, 8'h00, 32'h0, 32'h0, 4'h1, 4'h0, 8'hAA, 1'b1}, 200);
    apply('{1'b0, 4'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0}, 201);
    apply('{1'b1, 4'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0}, 202);
    apply('{1'b1, 4'h8, 8'h00, 32'h0, 32'h0, 4'h8, 4'h0, 8'h00, 1'b1}, 203);
    apply('{1'b1, 4'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h8, 8'hFF, 1'b0}, 204);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_unit_scheduler.md
# logic_unit_scheduler

Round-robin scheduler that shares one registered bitwise logic unit (NOT / OR / AND / XOR) between N requesters. It accepts operation requests, grants one requester at a time, executes the selected gate function on that requester's operands and returns the result with a one-hot completion pulse. It sits between the user-facing gate blocks and the single shared gate datapath, replacing per-requester gate instances.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, operand/result width in bits
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  N  per-requester request level; bit i belongs to requester i
- op  in  2N  per-requester opcode, op[2i+1:2i]; 00 NOT a, 01 a OR b, 10 a AND b, 11 a XOR b
- a  in  W·N  per-requester operand a, a[W(i+1)-1:Wi]
- b  in  W·N  per-requester operand b, same slicing; ignored for NOT
- gnt  out  N  one-hot grant pulse, one cycle
- done  out  N  one-hot completion pulse, one cycle, same bit as preceding gnt
- res  out  W  result of the most recently completed operation
- busy  out  1  high while an operation is in execution

## Operation
- Two states: IDLE, EXEC. Reset state IDLE.
- IDLE: if req == 0, stay; gnt, done low. Otherwise select winner i = first set bit of req searching upward from ptr, wrapping N-1 → 0. At that edge: gnt ← onehot(i), capture op/a/b slices of i into internal registers, ptr ← (i+1) mod N, state ← EXEC.
- EXEC: req ignored. At next edge: res ← f(op,a,b) of captured operands, done ← captured grant one-hot, gnt ← 0, state ← IDLE.
- f: NOT gives bitwise ~a (all W bits); OR/AND/XOR bitwise across W bits. No carries, no width growth.
- busy = (state == EXEC), combinational from state register.
- Operands used are those captured at the grant edge; changes on a/b/op after grant do not affect the result.
- Requester protocol: hold req, op, a, b stable until gnt seen; drop req on the edge after gnt unless another operation is wanted. req still high when IDLE samples it is a new request, handled by the round-robin search (ptr already advanced past it).
- res holds its value between done pulses.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,N-1,0,…; a requesting bit waits at most N-1 other grants.

## Timing
- Reset (rst_n low at an edge): state IDLE, gnt 0, done 0, res 0, busy 0, ptr 0, captured operands 0. Applies from any state; an EXEC in progress is aborted, no done issued.
- Latency: req high at edge E0 in IDLE → gnt high during cycle E0–E1 → done and res valid during cycle E1–E2.
- Throughput: at most one operation per 2 cycles; gnt and done never high in the same cycle; new gnt earliest the cycle after done.
- gnt and done are registered; no combinational path from req/op/a/b to any output.
- Simultaneous requests resolved only by ptr order; a request arriving during EXEC is sampled at the first IDLE edge.
- Request deasserted before being granted is simply dropped; no memory of it.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with req=4'b1111 → gnt, done, res, busy all 0; after release, first gnt = 4'b0001.
- Single op: requester 2, op=01, a=8'h0F, b=8'hA0 → gnt=4'b0100 one cycle later, done=4'b0100 and res=8'hAF the following cycle; busy high only in the gnt cycle.
- Opcodes: requester 0 with a=8'h3C, b=8'h0F, ops 00/01/10/11 in turn → res 8'hC3, 8'h3F, 8'h0C, 8'h33.
- Round-robin: req=4'b1111 held constant → gnt sequence 0001,0010,0100,1000,0001 every 2 cycles, each followed by matching done.
- Operand stability: grant requester 1 with a=8'h55 NOT, change a to 8'hFF in gnt cycle → res=8'hAA.
- Reset mid-op: assert rst_n=0 during EXEC → no done pulse, res=0; next request from requester 3 alone granted as gnt=4'b1000.
